tx_cpu_buf: RTL and testbench
=============================

// Module: tx_cpu_buf
// PURPOSE
//  CPU-side transmit staging buffer: the send-direction counterpart of the CPU receive path.
//  - Accepts byte or 16-bit word writes from the CPU bus interface.
//  - Serialises them, upper byte first, into an 8-bit TX FIFO write port.
//  - Holds at most two bytes in slots U (next out) and L; sits between the CPU register decode and the TX FIFO.
// PARAMETERS
//  BYTE_LANE  1  lane carrying a byte write: 1 = d[15:8], 0 = d[7:0]
// PORTS
//  clk        in   1   clock, all state updates on rising edge
//  reset      in   1   synchronous, active-high
//  wr_byte    in   1   CPU byte write strobe, 1 cycle per write
//  wr_word    in   1   CPU word write strobe, 1 cycle per write
//  d          in   16  CPU write data; word order {first, second}
//  fifo_full  in   1   TX FIFO cannot accept a byte this cycle
//  fifo_wr    out  1   push fifo_data into TX FIFO this cycle
//  fifo_data  out  8   byte presented to the FIFO (= slot U)
//  empty      out  1   both slots free; a word write is legal
//  full       out  1   both slots occupied; a byte write is illegal
//  overrun    out  1   sticky: an illegal write was dropped
// BEHAVIOUR
//  - State: u_full, l_full, u[7:0], l[7:0].
//    - Invariant !u_full => !l_full; the combination u_full=0, l_full=1 never occurs.
//  - Combinational outputs:
//    - empty = !u_full
//    - full = l_full
//    - fifo_data = u
//    - fifo_wr = u_full && !fifo_full; a pop occurs on every cycle fifo_wr=1.
//  - Reset: u_full=0, l_full=0, overrun=0, hence empty=1, full=0, fifo_wr=0.
//    - u and l are don't-care after reset.
//    - Reset overrides every write and pop in the same cycle, including a reset arriving mid-word (bytes discarded).
//  - Write legality, judged on pre-edge state:
//    - wr_byte is legal iff !full.
//    - wr_word is legal iff empty.
//    - An illegal write changes no slot and sets overrun.
//    - A pop in the same cycle does not make a write legal (no bypass).
//  - wr_byte and wr_word in the same cycle: wr_byte takes priority; wr_word is ignored and does not set overrun.
//  - Per-cycle update, first matching row applies:
//    1. Legal wr_byte, no pop: if !u_full then u<=B, u_full<=1; else l<=B, l_full<=1.
//    2. Legal wr_byte with pop (u_full, !l_full): u<=B; u_full stays 1.
//    3. Legal wr_word (no pop possible, U empty): u<=d[15:8], l<=d[7:0], u_full<=1, l_full<=1.
//    4. Pop only: u<=l, u_full<=l_full, l_full<=0.
//    5. Otherwise: hold.
//  - B = d[15:8] if BYTE_LANE=1, else d[7:0].
//  - Latency, with fifo_full low:
//    - A byte written at edge N is pushed on cycle N+1.
//    - A word written at edge N pushes its upper byte at N+1 and its lower byte at N+2.
//    - Sustained throughput is 1 byte/clk.
//  - fifo_full stalls indefinitely with no loss; the buffer holds its contents until space appears.
//  - overrun clears only on reset.
// TESTING
//  - Reset, then idle -> empty=1, full=0, fifo_wr=0, overrun=0 on every cycle.
//  - wr_word d=16'hA55A, fifo_full=0 -> fifo_wr with 8'hA5 next cycle, 8'h5A the cycle after, then empty=1.
//  - fifo_full=1; wr_byte 8'h11 then wr_byte 8'h22 -> full=1; a third wr_byte 8'h33 is dropped and sets overrun=1.
//    - Then release fifo_full -> 11, 22 pushed in order; 33 never appears.
//  - One byte pending with fifo_full=0; wr_byte 8'h77 in the pop cycle -> pending byte pushed, 8'h77 pushed next cycle, full never asserts.
//  - wr_word while one byte is pending -> ignored, overrun=1; the pending byte is still pushed intact.
//  - Assert reset in the cycle between the two pushes of a word -> second byte never pushed; empty=1 next cycle; overrun=0.

Source files
------------

// File: rtl/tx_cpu_buf.sv
// CPU-side transmit staging buffer: accepts byte/word CPU writes and serialises them,
// upper byte first, into an 8-bit TX FIFO write port through two slots (U next out, L behind).
module tx_cpu_buf #(
    parameter int unsigned BYTE_LANE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_byte,
    input  logic        wr_word,
    input  logic [15:0] d,
    input  logic        fifo_full,
    output logic        fifo_wr,
    output logic [7:0]  fifo_data,
    output logic        empty,
    output logic        full,
    output logic        overrun
);

    logic       u_full_q, u_full_d;
    logic       l_full_q, l_full_d;
    logic [7:0] u_q, u_d;
    logic [7:0] l_q, l_d;
    logic       overrun_q, overrun_d;

    logic [7:0] byte_in;
    logic       pop;
    logic       byte_legal;
    logic       word_sel;
    logic       word_legal;
    logic       write_illegal;

    if (BYTE_LANE != 0) begin : g_lane_hi
        assign byte_in = d[15:8];
    end else begin : g_lane_lo
        assign byte_in = d[7:0];
    end

    // Legality is judged on pre-edge state only; a same-cycle pop never frees a slot early.
    always_comb begin
        pop           = u_full_q && !fifo_full;
        byte_legal    = wr_byte && !l_full_q;
        word_sel      = wr_word && !wr_byte;
        word_legal    = word_sel && !u_full_q;
        write_illegal = (wr_byte && l_full_q) || (word_sel && u_full_q);
    end

    always_comb begin
        u_full_d  = u_full_q;
        l_full_d  = l_full_q;
        u_d       = u_q;
        l_d       = l_q;
        overrun_d = overrun_q || write_illegal;

        if (byte_legal && !pop) begin
            if (!u_full_q) begin
                u_d      = byte_in;
                u_full_d = 1'b1;
            end else begin
                l_d      = byte_in;
                l_full_d = 1'b1;
            end
        end else if (byte_legal && pop) begin
            // U drains this cycle and L is free, so the new byte takes U directly.
            u_d = byte_in;
        end else if (word_legal) begin
            u_d      = d[15:8];
            l_d      = d[7:0];
            u_full_d = 1'b1;
            l_full_d = 1'b1;
        end else if (pop) begin
            u_d      = l_q;
            u_full_d = l_full_q;
            l_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            u_full_q  <= 1'b0;
            l_full_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            u_full_q  <= u_full_d;
            l_full_q  <= l_full_d;
            overrun_q <= overrun_d;
        end
    end

    // Slot data carries no reset; it is only meaningful while the matching full flag is set.
    always_ff @(posedge clk) begin
        u_q <= u_d;
        l_q <= l_d;
    end

    always_comb begin
        empty     = !u_full_q;
        full      = l_full_q;
        fifo_data = u_q;
        fifo_wr   = pop;
        overrun   = overrun_q;
    end

endmodule

// File: tb/tb_tx_cpu_buf.sv
// Directed bench for tx_cpu_buf: linear stimulus with hand-computed expectations checked
// by immediate assertions between clock edges.
module tb_tx_cpu_buf;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_byte;
    logic        wr_word;
    logic [15:0] d;
    logic        fifo_full;
    logic        fifo_wr;
    logic [7:0]  fifo_data;
    logic        empty;
    logic        full;
    logic        overrun;

    int n_cmp = 0;
    int n_err = 0;

    tx_cpu_buf #(.BYTE_LANE(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_byte   (wr_byte),
        .wr_word   (wr_word),
        .d         (d),
        .fifo_full (fifo_full),
        .fifo_wr   (fifo_wr),
        .fifo_data (fifo_data),
        .empty     (empty),
        .full      (full),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Checks the four status outputs at once.
    task automatic chk_flags(input string tag, input logic e, input logic f, input logic w,
                             input logic o);
        chk({tag, ".empty"}, {7'd0, empty}, {7'd0, e});
        chk({tag, ".full"}, {7'd0, full}, {7'd0, f});
        chk({tag, ".fifo_wr"}, {7'd0, fifo_wr}, {7'd0, w});
        chk({tag, ".overrun"}, {7'd0, overrun}, {7'd0, o});
    endtask

    // Advance one clock edge, then settle inputs-to-outputs away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_byte = 1'b0;
        wr_word = 1'b0;
        d       = 16'h0000;
    endtask

    initial begin
        reset     = 1'b1;
        fifo_full = 1'b0;
        idle_inputs();
        step();
        step();
        reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk_flags("idle", 1'b1, 1'b0, 1'b0, 1'b0);
            step();
        end

        // Word A55A: A5 pushed next cycle, 5A the cycle after, then empty.
        wr_word = 1'b1;
        d       = 16'hA55A;
        step();
        idle_inputs();
        chk_flags("word_first", 1'b0, 1'b1, 1'b1, 1'b0);
        chk("word_first.data", fifo_data, 8'hA5);
        step();
        chk_flags("word_second", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("word_second.data", fifo_data, 8'h5A);
        step();
        chk_flags("word_done", 1'b1, 1'b0, 1'b0, 1'b0);

        // Stall: 11, 22 fill both slots, 33 is dropped and sets overrun.
        fifo_full = 1'b1;
        wr_byte   = 1'b1;
        d         = 16'h1100;
        step();
        chk_flags("stall_one", 1'b0, 1'b0, 1'b0, 1'b0);
        d = 16'h2200;
        step();
        chk_flags("stall_two", 1'b0, 1'b1, 1'b0, 1'b0);
        d = 16'h3300;
        step();
        idle_inputs();
        chk_flags("stall_drop", 1'b0, 1'b1, 1'b0, 1'b1);
        chk("stall_drop.data", fifo_data, 8'h11);
        step();
        chk("stall_hold.data", fifo_data, 8'h11);
        fifo_full = 1'b0;
        #1;
        chk_flags("drain_11", 1'b0, 1'b1, 1'b1, 1'b1);
        chk("drain_11.data", fifo_data, 8'h11);
        step();
        chk_flags("drain_22", 1'b0, 1'b0, 1'b1, 1'b1);
        chk("drain_22.data", fifo_data, 8'h22);
        step();
        chk_flags("drain_done", 1'b1, 1'b0, 1'b0, 1'b1);

        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk_flags("reset_clears", 1'b1, 1'b0, 1'b0, 1'b0);

        // Byte written in the pop cycle goes straight to U; full never asserts.
        wr_byte = 1'b1;
        d       = 16'h4400;
        step();
        d = 16'h7700;
        #1;
        chk_flags("pop_write", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("pop_write.data", fifo_data, 8'h44);
        step();
        idle_inputs();
        chk_flags("pop_write_next", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("pop_write_next.data", fifo_data, 8'h77);
        step();
        chk_flags("pop_write_done", 1'b1, 1'b0, 1'b0, 1'b0);

        // Simultaneous byte and word: byte wins, word ignored without overrun.
        wr_byte = 1'b1;
        wr_word = 1'b1;
        d       = 16'hC3D2;
        step();
        idle_inputs();
        chk_flags("both_strobes", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("both_strobes.data", fifo_data, 8'hC3);
        step();
        chk_flags("both_done", 1'b1, 1'b0, 1'b0, 1'b0);

        // Word while one byte is pending: ignored, overrun set, pending byte intact.
        fifo_full = 1'b1;
        wr_byte   = 1'b1;
        d         = 16'h9900;
        step();
        wr_byte = 1'b0;
        wr_word = 1'b1;
        d       = 16'hBEEF;
        step();
        idle_inputs();
        chk_flags("word_busy", 1'b0, 1'b0, 1'b0, 1'b1);
        chk("word_busy.data", fifo_data, 8'h99);
        fifo_full = 1'b0;
        #1;
        chk_flags("word_busy_pop", 1'b0, 1'b0, 1'b1, 1'b1);
        chk("word_busy_pop.data", fifo_data, 8'h99);
        step();
        chk_flags("word_busy_done", 1'b1, 1'b0, 1'b0, 1'b1);

        // Reset between the two pushes of a word discards the second byte.
        reset = 1'b1;
        step();
        reset   = 1'b0;
        wr_word = 1'b1;
        d       = 16'h1234;
        step();
        idle_inputs();
        chk("mid_word.data", fifo_data, 8'h12);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk_flags("mid_word_reset", 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        chk_flags("mid_word_after", 1'b1, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule
